// File: rtl/bch_encoder.sv
// Bit-serial systematic BCH(63,51) encoder: passes 51 message bits through,
// then appends the 12-bit remainder of m(x)*x^12 mod g(x), MSB first.
module bch_encoder #(
    parameter int             N   = 63,
    parameter int             K   = 51,
    parameter logic [N-K:0]   GEN = 13'h1539
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_data,
    output logic in_ready,
    output logic out_valid,
    output logic out_data,
    output logic out_last,
    input  logic out_ready
);

    localparam int P  = N - K;
    localparam int CW = $clog2(K);
    localparam logic [CW-1:0] CNT_MSG_LAST = CW'(K - 1);
    localparam logic [CW-1:0] CNT_PAR_LAST = CW'(P - 1);

    typedef enum logic {MSG, PAR} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [P-1:0]  r, r_nxt;
    logic          out_valid_nxt, out_data_nxt, out_last_nxt;
    logic          slot, fb;

    // The output register can take a new bit when empty or being drained.
    assign slot     = ~out_valid | out_ready;
    assign in_ready = rst & (state == MSG) & slot;
    assign fb       = in_data ^ r[P-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= MSG;
            cnt       <= '0;
            r         <= '0;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            r         <= r_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_last  <= out_last_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        r_nxt         = r;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_last_nxt  = out_last;

        if (out_ready) begin
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
        end

        case (state)
            MSG: begin
                if (in_valid && in_ready) begin
                    out_data_nxt  = in_data;
                    out_valid_nxt = 1'b1;
                    out_last_nxt  = 1'b0;
                    r_nxt = {r[P-2:0], 1'b0} ^ (fb ? GEN[P-1:0] : '0);
                    if (cnt == CNT_MSG_LAST) begin
                        state_nxt = PAR;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            PAR: begin
                // Remainder shifts out only when the output slot frees up.
                if (slot) begin
                    out_data_nxt  = r[P-1];
                    out_valid_nxt = 1'b1;
                    r_nxt         = {r[P-2:0], 1'b0};
                    if (cnt == CNT_PAR_LAST) begin
                        out_last_nxt = 1'b1;
                        state_nxt    = MSG;
                        cnt_nxt      = '0;
                        r_nxt        = '0;
                    end else begin
                        out_last_nxt = 1'b0;
                        cnt_nxt      = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = MSG;
        endcase
    end

endmodule
